// File: rtl/fmu_scoreboard.sv
// fmu_scoreboard: NUM_FLAGS-wide flag register with per-bit masked writes and
// jump-if-true/jump-if-false evaluation on a selected flag. It counts in-flight
// flag writers and holds a branch evaluation in WAIT until the flags it needs
// are final.
// Latency: result one cycle after an unblocked request. While waiting on
// pending writers, stall is high and eval_valid is ignored.
// Ports:
//   clk, rst_n     clock and async active-low reset
//   flag_code      flag selector; all ones = unconditional
//   sel_jt_jf      0 = jump-if-true, 1 = jump-if-false
//   eval_valid     branch requests an evaluation this cycle
//   issue_flag_wr  a flag-writing instruction has issued
//   write_enable   flag write from execute; retires one pending writer
//   flags_in       new flag values
//   flags_mask     per-bit write mask (1 = update bit)
//   jt_jf_ok       registered branch-taken result
//   eval_done      one-cycle completion pulse
//   stall          evaluation waiting on pending writers
//   flags_q        current flag register
//   err            sticky overflow/underflow/illegal-code flag
module fmu_scoreboard #(
  parameter int NUM_FLAGS = 6,
  parameter int CODE_W    = 5,
  parameter int PEND_MAX  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CODE_W-1:0]    flag_code,
  input  logic                 sel_jt_jf,
  input  logic                 eval_valid,
  input  logic                 issue_flag_wr,
  input  logic                 write_enable,
  input  logic [NUM_FLAGS-1:0] flags_in,
  input  logic [NUM_FLAGS-1:0] flags_mask,
  output logic                 jt_jf_ok,
  output logic                 eval_done,
  output logic                 stall,
  output logic [NUM_FLAGS-1:0] flags_q,
  output logic                 err
);

  localparam int PW = (PEND_MAX < 1) ? 1 : $clog2(PEND_MAX + 1);
  localparam logic [PW-1:0] PMAX = PW'(PEND_MAX);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  logic [PW-1:0]        pending;
  logic [CODE_W-1:0]    lat_code;
  logic                 lat_sel;

  logic [NUM_FLAGS-1:0] merged;
  logic [NUM_FLAGS-1:0] fwd;
  logic [PW-1:0]        pend_eff;
  logic                 blocked;
  logic [CODE_W-1:0]    cur_code;
  logic                 cur_sel;
  logic                 f_bit;
  logic                 code_hit;
  logic                 illegal;
  logic                 evaluating;
  logic                 overflow;
  logic                 underflow;

  always_comb begin
    merged = (flags_q & ~flags_mask) | (flags_in & flags_mask);
    fwd    = write_enable ? merged : flags_q;

    // A same-cycle issue belongs to a younger instruction, so only the
    // retiring write counts toward unblocking.
    pend_eff = pending;
    if (write_enable && pending != '0)
      pend_eff = pending - PW'(1);
    blocked = (pend_eff != '0);

    // In WAIT the latched request is evaluated, not the live inputs.
    cur_code = (state == WAIT) ? lat_code : flag_code;
    cur_sel  = (state == WAIT) ? lat_sel  : sel_jt_jf;

    f_bit    = 1'b0;
    code_hit = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (cur_code == CODE_W'(i)) begin
        f_bit    = fwd[i];
        code_hit = 1'b1;
      end
    end
    illegal = 1'b0;
    if (!code_hit) begin
      if (&cur_code) f_bit = 1'b1;
      else           illegal = 1'b1;
    end

    evaluating = !blocked && ((state == IDLE && eval_valid) || state == WAIT);
    overflow   = issue_flag_wr && !write_enable && pending == PMAX;
    underflow  = write_enable && !issue_flag_wr && pending == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      pending   <= '0;
      err       <= 1'b0;
      state     <= IDLE;
      stall     <= 1'b0;
      eval_done <= 1'b0;
      jt_jf_ok  <= 1'b0;
      lat_code  <= '0;
      lat_sel   <= 1'b0;
    end else begin
      if (write_enable)
        flags_q <= merged;

      // Saturate at both ends; simultaneous issue and retire cancel out.
      if (issue_flag_wr && !write_enable && !overflow)
        pending <= pending + PW'(1);
      else if (write_enable && !issue_flag_wr && !underflow)
        pending <= pending - PW'(1);

      if (overflow || underflow || (evaluating && illegal))
        err <= 1'b1;

      eval_done <= 1'b0;
      if (evaluating)
        jt_jf_ok <= f_bit ^ cur_sel;

      case (state)
        IDLE: begin
          if (eval_valid) begin
            if (blocked) begin
              lat_code <= flag_code;
              lat_sel  <= sel_jt_jf;
              state    <= WAIT;
              stall    <= 1'b1;
            end else begin
              eval_done <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!blocked) begin
            eval_done <= 1'b1;
            state     <= IDLE;
            stall     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmu_scoreboard.sv
module tb_fmu_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] flag_code = '0;
  logic       sel_jt_jf = 1'b0;
  logic       eval_valid = 1'b0;
  logic       issue_flag_wr = 1'b0;
  logic       write_enable = 1'b0;
  logic [5:0] flags_in = '0;
  logic [5:0] flags_mask = '0;
  logic       jt_jf_ok;
  logic       eval_done;
  logic       stall;
  logic [5:0] flags_q;
  logic       err;

  int tests = 0;
  int fails = 0;

  fmu_scoreboard #(.NUM_FLAGS(6), .CODE_W(5), .PEND_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .flag_code(flag_code), .sel_jt_jf(sel_jt_jf),
    .eval_valid(eval_valid), .issue_flag_wr(issue_flag_wr),
    .write_enable(write_enable), .flags_in(flags_in), .flags_mask(flags_mask),
    .jt_jf_ok(jt_jf_ok), .eval_done(eval_done), .stall(stall),
    .flags_q(flags_q), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    eval_valid = 0; issue_flag_wr = 0; write_enable = 0;
    flags_in = '0; flags_mask = '0; flag_code = '0; sel_jt_jf = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    tick();  // edge with rst_n still low
    tests++; if (flags_q !== 6'b0) begin fails++; $display("FAIL reset_flags got %b exp 000000", flags_q); end
    tests++; if ({jt_jf_ok, eval_done, stall, err} !== 4'b0) begin fails++; $display("FAIL reset_outs got %b exp 0000", {jt_jf_ok, eval_done, stall, err}); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write();
    // Paired with an issue so pending stays at 0 without underflow.
    issue_flag_wr = 1; write_enable = 1; flags_in = 6'b101010; flags_mask = 6'b111111;
    tick();
    idle_inputs();
    tests++; if (flags_q !== 6'b101010) begin fails++; $display("FAIL write_full got %b exp 101010", flags_q); end
    tests++; if ({jt_jf_ok, eval_done, stall, err} !== 4'b0) begin fails++; $display("FAIL write_outs got %b exp 0000", {jt_jf_ok, eval_done, stall, err}); end
  endtask

  task automatic test_masked_write();
    issue_flag_wr = 1; write_enable = 1; flags_in = 6'b010101; flags_mask = 6'b000011;
    tick();
    idle_inputs();
    tests++; if (flags_q !== 6'b101001) begin fails++; $display("FAIL masked_write got %b exp 101001", flags_q); end
  endtask

  task automatic test_eval();
    logic [4:0] codes [4] = '{5'd3, 5'd3, 5'd31, 5'd1};
    logic       sels  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       exps  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      eval_valid = 1; flag_code = codes[i]; sel_jt_jf = sels[i];
      tick();
      eval_valid = 0;
      tests++; if (eval_done !== 1'b1 || jt_jf_ok !== exps[i]) begin fails++; $display("FAIL eval_%0d done=%b ok=%b exp done=1 ok=%b", i, eval_done, jt_jf_ok, exps[i]); end
      tick();
      tests++; if (eval_done !== 1'b0 || jt_jf_ok !== exps[i]) begin fails++; $display("FAIL eval_hold_%0d done=%b ok=%b exp done=0 ok=%b", i, eval_done, jt_jf_ok, exps[i]); end
    end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL eval_err got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    // flags 101001: code 3 -> 1, code 1 -> 0, code 5 -> 1
    logic [4:0] codes [3] = '{5'd3, 5'd1, 5'd5};
    logic       exps  [3] = '{1'b1, 1'b0, 1'b1};
    eval_valid = 1; sel_jt_jf = 0;
    for (int i = 0; i < 3; i++) begin
      flag_code = codes[i];
      tick();
      if (i == 2) eval_valid = 0;
      tests++; if (eval_done !== 1'b1 || jt_jf_ok !== exps[i]) begin fails++; $display("FAIL b2b_%0d done=%b ok=%b exp done=1 ok=%b", i, eval_done, jt_jf_ok, exps[i]); end
    end
    tick();
    tests++; if (eval_done !== 1'b0) begin fails++; $display("FAIL b2b_end done=%b exp 0", eval_done); end
  endtask

  task automatic test_stall();
    issue_flag_wr = 1;
    tick(); tick();
    issue_flag_wr = 0;
    eval_valid = 1; flag_code = 5'd0; sel_jt_jf = 0;
    tick();
    eval_valid = 0;
    tests++; if (stall !== 1'b1 || eval_done !== 1'b0) begin fails++; $display("FAIL stall_rise stall=%b done=%b exp stall=1 done=0", stall, eval_done); end
    // First retire clears bit 0, so a result of 1 later proves forwarding.
    write_enable = 1; flags_in = 6'b000000; flags_mask = 6'b000001;
    tick();
    tests++; if (stall !== 1'b1 || eval_done !== 1'b0) begin fails++; $display("FAIL stall_hold stall=%b done=%b exp stall=1 done=0", stall, eval_done); end
    flags_in = 6'b000001; flags_mask = 6'b000001;
    tick();
    idle_inputs();
    tests++; if (eval_done !== 1'b1 || jt_jf_ok !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL stall_release done=%b ok=%b stall=%b exp 1 1 0", eval_done, jt_jf_ok, stall); end
    tests++; if (flags_q !== 6'b101001 || err !== 1'b0) begin fails++; $display("FAIL stall_flags flags=%b err=%b exp 101001 0", flags_q, err); end
    tick();
    tests++; if (eval_done !== 1'b0) begin fails++; $display("FAIL stall_pulse done=%b exp 0", eval_done); end
  endtask

  task automatic test_overflow();
    do_reset();
    issue_flag_wr = 1;
    for (int i = 0; i < 4; i++) tick();
    issue_flag_wr = 0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL overflow_err got %b exp 1", err); end
    // Saturated at 3: two retires leave one pending writer.
    write_enable = 1;
    tick(); tick();
    write_enable = 0;
    eval_valid = 1; flag_code = 5'd31; sel_jt_jf = 0;
    tick();
    eval_valid = 0;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL overflow_sat stall=%b exp 1", stall); end
    write_enable = 1;
    tick();
    write_enable = 0;
    tests++; if (eval_done !== 1'b1 || jt_jf_ok !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL overflow_drain done=%b ok=%b stall=%b exp 1 1 0", eval_done, jt_jf_ok, stall); end
  endtask

  task automatic test_underflow();
    do_reset();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL underflow_pre err=%b exp 0", err); end
    write_enable = 1;
    tick();
    write_enable = 0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL underflow_err got %b exp 1", err); end
  endtask

  task automatic test_illegal_code();
    do_reset();
    eval_valid = 1; flag_code = 5'd7; sel_jt_jf = 1;
    tick();
    sel_jt_jf = 0;
    tests++; if (eval_done !== 1'b1 || jt_jf_ok !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL illegal_sel1 done=%b ok=%b err=%b exp 1 1 1", eval_done, jt_jf_ok, err); end
    tick();
    eval_valid = 0;
    tests++; if (eval_done !== 1'b1 || jt_jf_ok !== 1'b0) begin fails++; $display("FAIL illegal_sel0 done=%b ok=%b exp 1 0", eval_done, jt_jf_ok); end
  endtask

  task automatic test_reset_wait();
    int extra_done;
    do_reset();
    issue_flag_wr = 1;
    tick();
    write_enable = 1;  // issue + retire together: pending stays 1
    tick();
    idle_inputs();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL simul_err got %b exp 0", err); end
    eval_valid = 1; flag_code = 5'd31; sel_jt_jf = 0;
    tick();
    eval_valid = 0;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL simul_pending stall=%b exp 1", stall); end
    #2 rst_n = 0;
    #1;
    tests++; if (stall !== 1'b0 || eval_done !== 1'b0) begin fails++; $display("FAIL rst_wait_async stall=%b done=%b exp 0 0", stall, eval_done); end
    #3 rst_n = 1;
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (eval_done !== 1'b0 || stall !== 1'b0) extra_done++;
    end
    tests++; if (extra_done !== 0) begin fails++; $display("FAIL rst_wait_abort got %0d stray cycles exp 0", extra_done); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_masked_write();
    test_eval();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_underflow();
    test_illegal_code();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
